// File: rtl/serial_add_arb.sv
// Bit-serial adder shared round-robin between two requesters; one result per WIDTH+2 cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             owner
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             pend_owner;
    logic             last_srv;
    logic             any_req;
    logic             winner;
    logic             last_bit;
    logic             s_bit;
    logic             c_bit;

    assign any_req  = req0 | req1;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign s_bit    = sh_a[0] ^ sh_b[0] ^ carry;
    assign c_bit    = (sh_a[0] & sh_b[0]) | ((sh_a[0] ^ sh_b[0]) & carry);
    // Sum bit enters at the MSB; after WIDTH steps bit 0 of the operands sits at bit 0.
    assign res_nx   = WIDTH'({s_bit, res} >> 1);

    // last_srv resets to 1 so that requester 0 wins the first contested round.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_srv;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ADD;
            ADD:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        gnt0 = (state == ADD) && (cnt == '0) && !pend_owner;
        gnt1 = (state == ADD) && (cnt == '0) && pend_owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a       <= '0;
            sh_b       <= '0;
            res        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            pend_owner <= 1'b0;
            last_srv   <= 1'b1;
        end else if (state == IDLE) begin
            if (any_req) begin
                sh_a       <= winner ? a1 : a0;
                sh_b       <= winner ? b1 : b0;
                carry      <= winner ? cin1 : cin0;
                pend_owner <= winner;
                last_srv   <= winner;
                cnt        <= '0;
            end
        end else if (state == ADD) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res   <= res_nx;
            carry <= c_bit;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            cout  <= 1'b0;
            owner <= 1'b0;
        end else if ((state == ADD) && last_bit) begin
            sum   <= res_nx;
            cout  <= c_bit;
            owner <= pend_owner;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the last step the carry register holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == ADD) && last_bit) begin
            ovf <= carry ^ c_bit;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Self-checking bench for serial_add_arb: directed cases plus randomized arbitration traffic.
module tb_serial_add_arb;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         cin0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         owner;

    int unsigned  checks;
    int unsigned  errors;
    logic [W-1:0] held_sum;
    bit           last_srv;
    bit           raise1;
    logic [W-1:0] r1a;
    logic [W-1:0] r1b;

    serial_add_arb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .cin0  (cin0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .cin1  (cin1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, gnt0, 0);
        check({tag, "_gnt1"}, gnt1, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_cout"}, cout, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_owner"}, owner, 0);
    endtask

    // Expects the already-driven request of `who` to be granted on the next cycle.
    task automatic wait_txn(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit ci, input bit drop);
        logic [W:0]  full;
        bit          exp_ovf;
        int unsigned n;
        full    = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        exp_ovf = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt0 | gnt1) && n < 20);
        check("gnt_latency", n, 1);
        check("gnt0", gnt0, {63'd0, !who});
        check("gnt1", gnt1, {63'd0, who});
        check("busy_gnt", busy, 1);
        last_srv = who;
        if (drop) begin
            if (who) req1 = 1'b0;
            else     req0 = 1'b0;
        end
        if (raise1) begin
            req1   = 1'b1;
            a1     = r1a;
            b1     = r1b;
            cin1   = 1'b0;
            raise1 = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) begin
                check("no_gnt_busy", {gnt0, gnt1}, 0);
                check("sum_held", sum, held_sum);
            end
        end while (!done && n < 40);
        check("done_latency", n, W);
        check("sum", sum, full[W-1:0]);
        check("cout", cout, full[W]);
        check("ovf", ovf, exp_ovf);
        check("owner", owner, who);
        check("busy_done", busy, 1);
        check("gnt_at_done", {gnt0, gnt1}, 0);
        held_sum = full[W-1:0];
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic run_one(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit ci);
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; cin0 = ci;
        end
        wait_txn(who, a, b, ci, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        last_srv = 1'b1;
        held_sum = '0;
        rst_n    = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        bit           rc;
        bit           r0;
        bit           r1;
        bit           w;
        checks = 0;
        errors = 0;
        raise1 = 1'b0;
        r1a = '0;
        r1b = '0;
        req0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
        req1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        do_reset();

        // Directed arithmetic cases
        run_one(1'b0, 8'h35, 8'h4A, 1'b0);
        run_one(1'b1, 8'hFF, 8'h01, 1'b0);
        run_one(1'b0, 8'h7F, 8'h01, 1'b0);
        run_one(1'b0, 8'h00, 8'h00, 1'b1);
        run_one(1'b1, 8'h80, 8'h80, 1'b0);

        // Both requesters held from reset: grants alternate 0, 1, 0
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0;
        req1 = 1'b1; a1 = 8'hC0; b1 = 8'h55; cin1 = 1'b1;
        do_reset();
        wait_txn(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_txn(1'b1, 8'hC0, 8'h55, 1'b1, 1'b0);
        wait_txn(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;

        // req1 raised while busy is served only after the current add finishes
        raise1 = 1'b1;
        r1a    = 8'h0F;
        r1b    = 8'hF1;
        run_one(1'b0, 8'h21, 8'h43, 1'b1);
        wait_txn(1'b1, 8'h0F, 8'hF1, 1'b0, 1'b1);

        // Reset in the 4th ADD cycle aborts the add
        req0 = 1'b1; a0 = 8'h66; b0 = 8'h77; cin0 = 1'b0;
        @(negedge clk);
        check("rst_gnt0", gnt0, 1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midop_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        last_srv = 1'b1;
        held_sum = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {done, busy}, 0);
        end
        run_one(1'b1, 8'hA5, 8'h5A, 1'b1);

        // Randomized traffic against the round-robin model
        for (int i = 0; i < 24; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            if (r0 && r1) w = ~last_srv;
            else          w = r1;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            sa = W'($urandom);
            sb = W'($urandom);
            req0 = r0; req1 = r1;
            if (w) begin
                a1 = ra; b1 = rb; cin1 = rc;
                a0 = sa; b0 = sb; cin0 = 1'b0;
            end else begin
                a0 = ra; b0 = rb; cin0 = rc;
                a1 = sa; b1 = sb; cin1 = 1'b0;
            end
            wait_txn(w, ra, rb, rc, 1'b1);
            req0 = 1'b0;
            req1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_arb.md
# serial_add_arb

Bit-serial adder controller that shares one full-adder slice between two requesters. It arbitrates round-robin between the requesters, captures the granted operands into shift registers and steps the one-bit full-adder datapath LSB-first for WIDTH cycles. It then presents the sum, carry-out, overflow and result owner for one done cycle. It sits between requester logic and the single-bit add resource, trading latency for area.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range 2..64.

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 add request; held until gnt0
- a0, b0  in  WIDTH  requester 0 operands
- cin0  in  1  requester 0 carry-in
- req1, a1, b1, cin1  in  1/WIDTH/WIDTH/1  same for requester 1
- gnt0, gnt1  out  1  one-cycle pulse: operands of that requester captured
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse: result valid
- sum  out  WIDTH  result, held until next done
- cout  out  1  unsigned carry-out, held
- ovf  out  1  signed overflow, held (see Configuration)
- owner  out  1  requester index of the held result

## Operation
- State machine: IDLE, ADD, DONE.
  - IDLE → ADD on an edge where req0|req1 is high.
  - ADD → DONE after exactly WIDTH ADD cycles.
  - DONE → IDLE unconditionally.
- Arbitration happens only in IDLE.
  - One requester asserting: that requester wins.
  - Both asserting: the winner is the requester not served last.
  - Pointer after reset favours requester 0; the pointer updates on every grant.
- On the IDLE→ADD edge:
  - Load the winner's a and b into shift registers and its cin into the carry register.
  - Record the winner as the pending owner.
  - Clear the bit counter.
- Each ADD cycle:
  - s = a[0]^b[0]^c
  - c_next = (a[0]&b[0]) | ((a[0]^b[0])&c)
  - a and b shift right by one; s shifts into the MSB of the result shift register.
  - The counter increments.
- On the ADD→DONE edge:
  - Transfer the result register to sum, final carry to cout, pending owner to owner.
  - Load ovf = carry into MSB XOR carry out of MSB.
- Requesters must hold req and operands stable until their gnt is seen, then drop req.
  - A req still high on the next IDLE edge is treated as a new request.
- Requests arriving during ADD or DONE are ignored until IDLE; they are not queued.
- Async reset, including mid-operation, aborts the add with no done.
  - Every output goes to 0 and state goes to IDLE.
  - Pointer returns to favour requester 0.

## Timing
- Edge E0: IDLE samples req and captures operands.
- gntX is high in the cycle following E0, which is the first ADD cycle.
- ADD occupies the cycles E0..E(WIDTH); DONE follows edge E(WIDTH).
- done is high for one cycle, WIDTH cycles after the gnt cycle.
- sum, cout, ovf and owner update on the same edge done rises and stay stable until the next done.
- The next capture is at E(WIDTH+2) at the earliest, so throughput is one add per WIDTH+2 cycles.
- busy is high from the gnt cycle through the done cycle inclusive.
- gnt0 and gnt1 are never high together; done and gnt are never high together.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Track the carry into the MSB.
  - ovf is registered as described and held with sum.
- SERIAL_ADD_OVF_EN undefined:
  - No MSB-carry tracking logic.
  - ovf is tied to 0.
  - All other behaviour and timing are identical.

## Test plan
- Basic add (WIDTH=8): req0, a0=0x35, b0=0x4A, cin0=0.
  - Required: gnt0 the cycle after the sample edge; done 8 cycles later.
  - Required: sum=0x7F, cout=0, ovf=0, owner=0.
- Unsigned carry-out: req1, a1=0xFF, b1=0x01, cin1=0.
  - Required: sum=0x00, cout=1, ovf=0, owner=1.
- Signed overflow and carry-in:
  - a0=0x7F, b0=0x01 → sum=0x80, ovf=1 (0 with SERIAL_ADD_OVF_EN undefined).
  - a0=0x00, b0=0x00, cin0=1 → sum=0x01.
- Simultaneous requests: req0 and req1 held high from reset, distinct operands.
  - Required: gnt0 first, then gnt1 on the next IDLE edge.
  - Required: owner sequence 0, 1, then 0 again if both are still requesting.
- Busy window: req1 raised during ADD.
  - Required: no gnt1 until IDLE; held sum is unchanged until the next done.
- Reset mid-operation: rst_n low in the 4th ADD cycle.
  - Required: all outputs 0 immediately and no done pulse.
  - Required: after release, req1 alone is granted normally.
